axis_drr_arbiter: RTL

AXIS_DRR_ARBITER -- requirements
Module: axis_drr_arbiter

---
 rtl/axis_drr_pkg.sv | 33 +++
 rtl/axis_drr_deficit.sv | 47 ++++
 rtl/axis_drr_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/axis_drr_pkg.sv
// Shared types and saturating helpers for the deficit round-robin AXI-Stream arbiter.
package axis_drr_pkg;

  typedef enum logic {
    StScan = 1'b0,
    StXfer = 1'b1
  } drr_state_e;

  // Clamp a+b to the signed range of a w-bit counter (w <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned       w);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    logic signed [63:0] s;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    s  = a + b;
    if (s > mx) begin
      return mx;
    end else if (s < mn) begin
      return mn;
    end
    return s;
  endfunction

  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned       w);
    return sat_add(a, -b, w);
  endfunction

endpackage

// File: rtl/axis_drr_deficit.sv
// One port's signed deficit counter with saturating credit, debit and positive-clear.
module axis_drr_deficit #(
  parameter int unsigned DEFICIT_WIDTH = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_credit,
  input  logic        [DEFICIT_WIDTH-2:0] i_quantum,
  input  logic                            i_clear_pos,
  input  logic                            i_dec,
  output logic signed [DEFICIT_WIDTH-1:0] o_deficit,
  output logic signed [DEFICIT_WIDTH-1:0] o_credited,
  output logic signed [DEFICIT_WIDTH-1:0] o_decremented
);
  import axis_drr_pkg::*;

  logic signed [DEFICIT_WIDTH-1:0] r_deficit;
  logic signed [63:0]              w_cur;
  logic signed [63:0]              w_qext;
  logic signed [63:0]              w_add;
  logic signed [63:0]              w_sub;
  logic                            w_pos;

  assign w_cur  = {{(64 - DEFICIT_WIDTH){r_deficit[DEFICIT_WIDTH-1]}}, r_deficit};
  assign w_qext = {{(65 - DEFICIT_WIDTH){1'b0}}, i_quantum};
  assign w_add  = sat_add(w_cur, w_qext, DEFICIT_WIDTH);
  assign w_sub  = sat_sub(w_cur, 64'sd1, DEFICIT_WIDTH);
  assign w_pos  = !r_deficit[DEFICIT_WIDTH-1] && (r_deficit != '0);

  assign o_deficit     = r_deficit;
  assign o_credited    = w_add[DEFICIT_WIDTH-1:0];
  assign o_decremented = w_sub[DEFICIT_WIDTH-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_deficit <= '0;
    end else if (i_credit) begin
      r_deficit <= o_credited;
    end else if (i_dec) begin
      r_deficit <= o_decremented;
    end else if (i_clear_pos && w_pos) begin
      // Idle ports forfeit surplus credit but keep any debt.
      r_deficit <= '0;
    end
  end

endmodule

// File: rtl/axis_drr_arbiter.sv
// Deficit round-robin AXI-Stream packet arbiter; packet-atomic grants, zero-latency data path.
// Optional per-port packet counters on pkt_count when AXIS_DRR_PKT_STATS_EN is defined.
module axis_drr_arbiter #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned AXIS_BUS_WIDTH  = 64,
  parameter int unsigned AXIS_ID_WIDTH   = 4,
  parameter int unsigned AXIS_DEST_WIDTH = 4,
  parameter int unsigned DEFICIT_WIDTH   = 16,
  localparam int unsigned KEEP_W         = AXIS_BUS_WIDTH / 8,
  localparam int unsigned PTR_W          = $clog2(NUM_PORTS)
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [NUM_PORTS*AXIS_BUS_WIDTH-1:0]    axis_s_tdata,
  input  logic [NUM_PORTS*AXIS_ID_WIDTH-1:0]     axis_s_tid,
  input  logic [NUM_PORTS*AXIS_DEST_WIDTH-1:0]   axis_s_tdest,
  input  logic [NUM_PORTS*KEEP_W-1:0]            axis_s_tkeep,
  input  logic [NUM_PORTS-1:0]                   axis_s_tlast,
  input  logic [NUM_PORTS-1:0]                   axis_s_tvalid,
  output logic [NUM_PORTS-1:0]                   axis_s_tready,
  output logic [AXIS_BUS_WIDTH-1:0]              axis_m_tdata,
  output logic [AXIS_ID_WIDTH-1:0]               axis_m_tid,
  output logic [AXIS_DEST_WIDTH-1:0]             axis_m_tdest,
  output logic [KEEP_W-1:0]                      axis_m_tkeep,
  output logic                                   axis_m_tlast,
  output logic                                   axis_m_tvalid,
  input  logic                                   axis_m_tready,
  input  logic [NUM_PORTS*(DEFICIT_WIDTH-1)-1:0] quantum,
  output logic [PTR_W-1:0]                       grant_port,
  output logic                                   busy
`ifdef AXIS_DRR_PKT_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]                pkt_count
`endif
);
  import axis_drr_pkg::*;

  drr_state_e                      r_state;
  drr_state_e                      w_state_nxt;
  logic [PTR_W-1:0]                r_ptr;
  logic [PTR_W-1:0]                w_ptr_nxt;
  logic [PTR_W-1:0]                r_grant;
  logic [PTR_W-1:0]                w_grant_nxt;
  logic                            r_fresh;
  logic                            w_fresh_nxt;
  logic [PTR_W-1:0]                w_ptr_adv;
  logic [PTR_W-1:0]                w_grant_adv;
  logic [NUM_PORTS-1:0]            w_credit;
  logic [NUM_PORTS-1:0]            w_clear_pos;
  logic [NUM_PORTS-1:0]            w_dec;
  logic signed [DEFICIT_WIDTH-1:0] w_deficit     [NUM_PORTS];
  logic signed [DEFICIT_WIDTH-1:0] w_credited    [NUM_PORTS];
  logic signed [DEFICIT_WIDTH-1:0] w_decremented [NUM_PORTS];
  logic signed [DEFICIT_WIDTH-1:0] w_scan_val;
  logic                            w_accept;
  logic                            w_last_accept;

  function automatic logic is_pos(input logic signed [DEFICIT_WIDTH-1:0] v);
    return !v[DEFICIT_WIDTH-1] && (v != '0);
  endfunction

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_def
    axis_drr_deficit #(
      .DEFICIT_WIDTH(DEFICIT_WIDTH)
    ) u_def (
      .i_clk        (aclk),
      .i_rst        (areset),
      .i_credit     (w_credit[g]),
      .i_quantum    (quantum[g*(DEFICIT_WIDTH-1) +: (DEFICIT_WIDTH-1)]),
      .i_clear_pos  (w_clear_pos[g]),
      .i_dec        (w_dec[g]),
      .o_deficit    (w_deficit[g]),
      .o_credited   (w_credited[g]),
      .o_decremented(w_decremented[g])
    );
  end

  assign busy        = (r_state == StXfer);
  assign grant_port  = r_grant;
  assign w_ptr_adv   = (r_ptr == PTR_W'(NUM_PORTS - 1)) ? '0 : r_ptr + 1'b1;
  assign w_grant_adv = (r_grant == PTR_W'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
  assign w_scan_val  = r_fresh ? w_credited[r_ptr] : w_deficit[r_ptr];

  assign w_accept      = busy & axis_s_tvalid[r_grant] & axis_m_tready;
  assign w_last_accept = w_accept & axis_s_tlast[r_grant];

  always_comb begin
    axis_m_tdata  = axis_s_tdata[r_grant*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
    axis_m_tid    = axis_s_tid[r_grant*AXIS_ID_WIDTH +: AXIS_ID_WIDTH];
    axis_m_tdest  = axis_s_tdest[r_grant*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
    axis_m_tkeep  = axis_s_tkeep[r_grant*KEEP_W +: KEEP_W];
    axis_m_tlast  = axis_s_tlast[r_grant];
    axis_m_tvalid = busy & axis_s_tvalid[r_grant];
    axis_s_tready = '0;
    if (busy) begin
      axis_s_tready[r_grant] = axis_m_tready;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_fresh_nxt = r_fresh;
    w_credit    = '0;
    w_clear_pos = '0;
    w_dec       = '0;
    unique case (r_state)
      StScan: begin
        if (axis_s_tvalid[r_ptr]) begin
          w_credit[r_ptr] = r_fresh;
          if (is_pos(w_scan_val)) begin
            w_grant_nxt = r_ptr;
            w_state_nxt = StXfer;
          end else begin
            w_ptr_nxt   = w_ptr_adv;
            w_fresh_nxt = 1'b1;
          end
        end else begin
          w_clear_pos[r_ptr] = 1'b1;
          w_ptr_nxt          = w_ptr_adv;
          w_fresh_nxt        = 1'b1;
        end
      end
      StXfer: begin
        w_dec[r_grant] = w_accept;
        if (w_last_accept) begin
          w_state_nxt = StScan;
          // Leftover credit lets the same port go again without a fresh quantum.
          if (is_pos(w_decremented[r_grant])) begin
            w_ptr_nxt   = r_grant;
            w_fresh_nxt = 1'b0;
          end else begin
            w_ptr_nxt   = w_grant_adv;
            w_fresh_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = StScan;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= StScan;
      r_ptr   <= '0;
      r_grant <= '0;
      r_fresh <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_fresh <= w_fresh_nxt;
    end
  end

`ifdef AXIS_DRR_PKT_STATS_EN
  logic [31:0] r_pkt_cnt [NUM_PORTS];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_pkt_cnt[i] <= '0;
      end
    end else if (w_last_accept) begin
      r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign pkt_count[g*32 +: 32] = r_pkt_cnt[g];
  end
`endif

endmodule
